// File: rtl/alu_result_pipe.sv
// -----------------------------------------------------------------------------
// alu_result_pipe
//   Execute-to-writeback stage sitting directly behind the RISC-16 ALU.
//   Captures the ALU result with its destination tag and write enable, and
//   presents it to writeback over valid/ready. A 2-entry skid buffer (head +
//   skid register) keeps in_ready a pure register output while still allowing
//   one transfer per cycle with no bubbles. The zero/negative flags are derived
//   from the head entry. Writes to r0 are optionally suppressed.
//
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   in_valid     upstream result valid
//   in_ready     stage can accept (registered)
//   in_result    ALU result, captured on in_valid & in_ready
//   in_rd        destination register index
//   in_we        instruction writes a register
//   out_valid    head entry valid
//   out_ready    writeback consumes the head entry
//   out_result   head result
//   out_rd       head destination index
//   out_we       head write enable, after r0 suppression
//   out_zero     head result == 0
//   out_neg      head result sign bit
//   occupancy    entries held (0, 1 or 2)
// -----------------------------------------------------------------------------
module alu_result_pipe #(
  parameter int WIDTH      = 16,
  parameter int RD_W       = 3,
  parameter bit R0_NOWRITE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_we,
  output logic             out_zero,
  output logic             out_neg,
  output logic [1:0]       occupancy
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [RD_W-1:0]  rd;
    logic             we;
  } entry_t;

  // Encoding matches the entry count, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;

  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  assign in_entry = '{result: in_result, rd: in_rd, we: in_we};
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  // Next-state logic for the skid buffer.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_entry;
        end else if (in_fire) begin
          skid_d  = in_entry;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // in_ready is computed from the next state so it is a flop output, and it
    // stays low until the first clock edge after reset is released.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, so the head outputs read as
      // defined zeros (not X) right after reset.
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign occupancy  = state_q;
  assign out_result = main_q.result;
  assign out_rd     = main_q.rd;
  assign out_we     = main_q.we & ~(R0_NOWRITE && (main_q.rd == '0));
  assign out_zero   = (main_q.result == '0);
  assign out_neg    = main_q.result[WIDTH-1];

endmodule

// File: tb/tb_alu_result_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_result_pipe
//   Self-checking bench for alu_result_pipe: reset values, single-entry flag and
//   r0-suppression vectors, streaming, backpressure, mid-stream reset and a
//   random valid/ready run against an in-order scoreboard. A second instance
//   with R0_NOWRITE=0 shares the inputs to cover the unsuppressed write enable.
// -----------------------------------------------------------------------------
module tb_alu_result_pipe;

  localparam int WIDTH = 16;
  localparam int RD_W  = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [RD_W-1:0]  in_rd;
  logic             in_we;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [RD_W-1:0]  out_rd;
  logic             out_we;
  logic             out_zero;
  logic             out_neg;
  logic [1:0]       occupancy;

  // Outputs of the R0_NOWRITE=0 instance.
  logic             n_in_ready;
  logic             n_out_valid;
  logic [WIDTH-1:0] n_out_result;
  logic [RD_W-1:0]  n_out_rd;
  logic             n_out_we;
  logic             n_out_zero;
  logic             n_out_neg;
  logic [1:0]       n_occupancy;

  alu_result_pipe #(.WIDTH(WIDTH), .RD_W(RD_W), .R0_NOWRITE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
    .out_zero(out_zero), .out_neg(out_neg), .occupancy(occupancy)
  );

  alu_result_pipe #(.WIDTH(WIDTH), .RD_W(RD_W), .R0_NOWRITE(1'b0)) dut_nr0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(n_in_ready),
    .in_result(in_result), .in_rd(in_rd), .in_we(in_we),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .out_result(n_out_result), .out_rd(n_out_rd), .out_we(n_out_we),
    .out_zero(n_out_zero), .out_neg(n_out_neg), .occupancy(n_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [WIDTH-1:0] result;
    logic [RD_W-1:0]  rd;
    logic             we;
    logic             exp_zero;
    logic             exp_neg;
    logic             exp_we;
    logic             exp_we_nr0;
  } vec_t;

  vec_t vecs[7];

  // Scoreboard entry: {result, rd, expected out_we}.
  typedef logic [WIDTH+RD_W:0] sb_t;
  sb_t sb_q[$];

  initial begin
    vecs[0] = '{16'h0000, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{16'h8000, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{16'h7FFF, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{16'h1234, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'hABCD, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_rd     = '0;
    in_we     = 1'b0;
    out_ready = 1'b0;

    // ---------------- reset values ----------------
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_we", out_we, 0);
    check("rst_out_zero", out_zero, 1);
    check("rst_out_neg", out_neg, 0);
    repeat (2) tick();
    check("rst_in_ready_held", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_pre_edge", in_ready, 0);
    tick();
    check("rel_in_ready_post_edge", in_ready, 1);
    check("rel_out_valid", out_valid, 0);

    // ---------------- single-entry vectors: flags and r0 suppression -------
    for (int i = 0; i < 7; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_result = vecs[i].result;
      in_rd     = vecs[i].rd;
      in_we     = vecs[i].we;
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_out_valid", i), out_valid, 1);
      check($sformatf("vec%0d_occupancy", i), occupancy, 1);
      check($sformatf("vec%0d_out_result", i), out_result, vecs[i].result);
      check($sformatf("vec%0d_out_rd", i), out_rd, vecs[i].rd);
      check($sformatf("vec%0d_out_zero", i), out_zero, vecs[i].exp_zero);
      check($sformatf("vec%0d_out_neg", i), out_neg, vecs[i].exp_neg);
      check($sformatf("vec%0d_out_we", i), out_we, vecs[i].exp_we);
      check($sformatf("vec%0d_out_we_nr0", i), n_out_we, vecs[i].exp_we_nr0);
      out_ready = 1'b1;
      tick();
      check($sformatf("vec%0d_drained", i), occupancy, 0);
    end

    // ---------------- streaming 0x0001..0x0010, 1-cycle latency ----------
    out_ready = 1'b1;
    in_rd     = 3'd4;
    in_we     = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid  = 1'b1;
      in_result = 16'(i);
      tick();
      check($sformatf("stream%0d_in_ready", i), in_ready, 1);
      check($sformatf("stream%0d_out_valid", i), out_valid, 1);
      check($sformatf("stream%0d_out_result", i), out_result, 32'(i));
      check($sformatf("stream%0d_occupancy", i), occupancy, 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_out_valid", out_valid, 0);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_result = 16'h1234;
    tick();
    in_result = 16'h5678;
    tick();
    check("bp_occupancy_full", occupancy, 2);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_head_1234", out_result, 16'h1234);
    // An offer while full must be ignored.
    in_result = 16'hDEAD;
    tick();
    in_valid = 1'b0;
    check("bp_hold_occupancy", occupancy, 2);
    check("bp_hold_head", out_result, 16'h1234);
    out_ready = 1'b1;
    tick();
    check("bp_drain1_result", out_result, 16'h5678);
    check("bp_drain1_occupancy", occupancy, 1);
    check("bp_drain1_in_ready", in_ready, 1);
    tick();
    check("bp_drain2_occupancy", occupancy, 0);
    check("bp_drain2_out_valid", out_valid, 0);

    // ---------------- reset mid-stream with two entries held ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_result = 16'hAAAA;
    tick();
    in_result = 16'hBBBB;
    tick();
    check("mrst_pre_occupancy", occupancy, 2);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_occupancy", occupancy, 0);
    check("mrst_in_ready", in_ready, 0);
    check("mrst_out_result", out_result, 0);
    in_result = 16'hCCCC;
    tick();
    check("mrst_ignore_inputs", out_valid, 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    check("mrst_rel_in_ready", in_ready, 1);
    check("mrst_rel_out_valid", out_valid, 0);
    check("mrst_rel_occupancy", occupancy, 0);

    // ---------------- random valid/ready, 10k transfers ----------------
    begin
      int done_cnt = 0;
      int cycles   = 0;
      while (done_cnt < 10000 && cycles < 60000) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        in_result = 16'($urandom);
        in_rd     = 3'($urandom);
        in_we     = 1'($urandom);
        @(negedge clk);
        check("rnd_occupancy", 32'(occupancy), 32'(sb_q.size()));
        if (occupancy > 2'd2) check("rnd_occupancy_max", occupancy, 2);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("rnd_unexpected_output", 1, 0);
          end else begin
            check("rnd_head", {out_result, out_rd, out_we}, sb_q.pop_front());
          end
          done_cnt++;
        end
        if (in_valid && in_ready)
          sb_q.push_back({in_result, in_rd, in_we & (in_rd != '0)});
        tick();
        cycles++;
      end
      check("rnd_transfer_budget", (done_cnt >= 10000), 1);

      // Drain what is left, bounded.
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cycles    = 0;
      while (sb_q.size() != 0 && cycles < 10) begin
        @(negedge clk);
        if (out_valid) check("drain_head", {out_result, out_rd, out_we}, sb_q.pop_front());
        else check("drain_out_valid", out_valid, 1);
        tick();
        cycles++;
      end
      check("drain_empty_sb", sb_q.size(), 0);
      check("drain_empty_dut", occupancy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
